// File: rtl/sr_drv_pkg.sv
// Shared types and sizing helpers for the SR command driver.
// Optional build macro: SR_SKIP_REDUNDANT_EN (consumed in sr_cmd_driver).
package sr_drv_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE_S = 2'd1,
      PULSE_R = 2'd2,
      GAP     = 2'd3
   } state_t;

   localparam int DEF_DB_CYCLES = 4;
   localparam int DEF_PULSE_W   = 2;
   localparam int DEF_GAP_W     = 1;

   // Bits needed to hold any value 0..max_val.
   function automatic int cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser plus DB_CYCLES debounce for one raw request line.
// The rise output is a registered one-cycle event on each 0->1 of the debounced level.
module sr_debounce
   import sr_drv_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   output logic level,
   output logic rise
);

   localparam int            CW      = cnt_w(DB_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level_d;
   logic [CW-1:0] cnt;

   // NOTE: non-blocking assignments make sync1 -> sync2 a genuine two-stage chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         rise    <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= req;
         sync2   <= sync1;
         level_d <= level;
         rise    <= level & ~level_d;
         if (sync2 != level) begin
            // The DB_CYCLES-th consecutive mismatch commits the new level.
            if (cnt == DB_LAST) begin
               level <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/sr_cmd_driver.sv
// Turns debounced set/clear requests into non-overlapping S/R pulses with a guard gap.
// Optional build macro SR_SKIP_REDUNDANT_EN drops commands that would not change Q_EST.
module sr_cmd_driver
   import sr_drv_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES,
   parameter int PULSE_W   = DEF_PULSE_W,
   parameter int GAP_W     = DEF_GAP_W
) (
   input  logic CLK,
   input  logic RST,
   input  logic SET_REQ,
   input  logic CLR_REQ,
   output logic S,
   output logic R,
   output logic BUSY,
   output logic Q_EST,
   output logic CONFLICT
);

   localparam int            PW     = cnt_w(PULSE_W);
   localparam int            GW     = cnt_w(GAP_W);
   localparam logic [PW-1:0] P_LAST = PW'(PULSE_W - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP_W - 1);

   logic set_level, clr_level;
   logic set_ev, clr_ev;

   state_t        state, state_nxt;
   logic [PW-1:0] pulse_cnt, pulse_cnt_nxt;
   logic [GW-1:0] gap_cnt, gap_cnt_nxt;
   logic          set_pend, set_pend_nxt;
   logic          clr_pend, clr_pend_nxt;
   logic          q_nxt;

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
      .clk   (CLK),
      .rst   (RST),
      .req   (SET_REQ),
      .level (set_level),
      .rise  (set_ev)
   );

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
      .clk   (CLK),
      .rst   (RST),
      .req   (CLR_REQ),
      .level (clr_level),
      .rise  (clr_ev)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt     = state;
      pulse_cnt_nxt = pulse_cnt;
      gap_cnt_nxt   = gap_cnt;
      q_nxt         = Q_EST;
      set_pend_nxt  = set_pend;
      clr_pend_nxt  = clr_pend;

      // New events override stored ones; simultaneous events cancel each other.
      if (set_ev && clr_ev) begin
         set_pend_nxt = 1'b0;
         clr_pend_nxt = 1'b0;
      end else if (set_ev) begin
         set_pend_nxt = 1'b1;
         clr_pend_nxt = 1'b0;
      end else if (clr_ev) begin
         set_pend_nxt = 1'b0;
         clr_pend_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            pulse_cnt_nxt = '0;
            gap_cnt_nxt   = '0;
            if (set_pend_nxt) begin
               set_pend_nxt = 1'b0;
`ifdef SR_SKIP_REDUNDANT_EN
               if (!Q_EST) state_nxt = PULSE_S;
`else
               state_nxt = PULSE_S;
`endif
            end else if (clr_pend_nxt) begin
               clr_pend_nxt = 1'b0;
`ifdef SR_SKIP_REDUNDANT_EN
               if (Q_EST) state_nxt = PULSE_R;
`else
               state_nxt = PULSE_R;
`endif
            end
         end
         PULSE_S: begin
            if (pulse_cnt == P_LAST) begin
               state_nxt     = GAP;
               pulse_cnt_nxt = '0;
               q_nxt         = 1'b1;
            end else begin
               pulse_cnt_nxt = pulse_cnt + 1'b1;
            end
         end
         PULSE_R: begin
            if (pulse_cnt == P_LAST) begin
               state_nxt     = GAP;
               pulse_cnt_nxt = '0;
               q_nxt         = 1'b0;
            end else begin
               pulse_cnt_nxt = pulse_cnt + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == G_LAST) begin
               state_nxt   = IDLE;
               gap_cnt_nxt = '0;
            end else begin
               gap_cnt_nxt = gap_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // S and R are decoded from a single next-state value, so they can never both be set.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         pulse_cnt <= '0;
         gap_cnt   <= '0;
         set_pend  <= 1'b0;
         clr_pend  <= 1'b0;
         Q_EST     <= 1'b0;
         S         <= 1'b0;
         R         <= 1'b0;
         CONFLICT  <= 1'b0;
      end else begin
         state     <= state_nxt;
         pulse_cnt <= pulse_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         set_pend  <= set_pend_nxt;
         clr_pend  <= clr_pend_nxt;
         Q_EST     <= q_nxt;
         S         <= (state_nxt == PULSE_S);
         R         <= (state_nxt == PULSE_R);
         CONFLICT  <= set_ev & clr_ev;
      end
   end

   assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed self-checking bench for sr_cmd_driver (DB_CYCLES=4, PULSE_W=2, GAP_W=1).
// Honours SR_SKIP_REDUNDANT_EN when the design is built with it.
module tb_sr_cmd_driver;

   logic CLK = 1'b0;
   logic RST;
   logic SET_REQ;
   logic CLR_REQ;
   logic S, R, BUSY, Q_EST, CONFLICT;

   int checks   = 0;
   int failures = 0;
   int overlap  = 0;

   sr_cmd_driver #(
      .DB_CYCLES (4),
      .PULSE_W   (2),
      .GAP_W     (1)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .SET_REQ  (SET_REQ),
      .CLR_REQ  (CLR_REQ),
      .S        (S),
      .R        (R),
      .BUSY     (BUSY),
      .Q_EST    (Q_EST),
      .CONFLICT (CONFLICT)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (S && R) overlap++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic window(input int n, output int sc, output int rc, output int bc, output int cc);
      sc = 0; rc = 0; bc = 0; cc = 0;
      repeat (n) begin
         tick();
         sc += int'(S);
         rc += int'(R);
         bc += int'(BUSY);
         cc += int'(CONFLICT);
      end
   endtask

   int sc, rc, bc, cc;
   int exp_s, exp_b;
   logic [16:0] s_tr, r_tr;

   initial begin
      RST = 1'b1; SET_REQ = 1'b0; CLR_REQ = 1'b0;
      #12;
      check("reset_outputs", {S, R, BUSY, Q_EST, CONFLICT}, 5'b0);
      #10 RST = 1'b0;
      tick();

      // Short glitches never survive the debounce.
      sc = 0; bc = 0;
      for (int i = 0; i < 24; i++) begin
         SET_REQ = ((i % 4) < 2);
         tick();
         sc += int'(S);
         bc += int'(BUSY);
      end
      SET_REQ = 1'b0;
      window(10, exp_s, rc, exp_b, cc);
      check("glitch_s", sc + exp_s, 0);
      check("glitch_busy", bc + exp_b, 0);

      // Clean set: S high at edges 8 and 9, GAP at 10, IDLE at 11.
      SET_REQ = 1'b1;
      ticks(7);
      check("set_s_edge7", S, 1'b0);
      tick();
      check("set_s_edge8", S, 1'b1);
      check("set_busy_edge8", BUSY, 1'b1);
      tick();
      check("set_s_edge9", S, 1'b1);
      tick();
      check("set_s_edge10", S, 1'b0);
      check("set_busy_edge10", BUSY, 1'b1);
      check("set_q_edge10", Q_EST, 1'b1);
      tick();
      check("set_busy_edge11", BUSY, 1'b0);
      SET_REQ = 1'b0;
      ticks(10);

      // Two further set commands while Q_EST is already 1.
`ifdef SR_SKIP_REDUNDANT_EN
      exp_s = 0; exp_b = 0;
`else
      exp_s = 2; exp_b = 3;
`endif
      for (int k = 0; k < 2; k++) begin
         SET_REQ = 1'b1;
         window(14, sc, rc, bc, cc);
         check("redundant_s_cycles", sc, exp_s);
         check("redundant_busy_cycles", bc, exp_b);
         check("redundant_q", Q_EST, 1'b1);
         SET_REQ = 1'b0;
         ticks(10);
      end

      // Simultaneous set and clear cancel and flag a conflict.
      SET_REQ = 1'b1; CLR_REQ = 1'b1;
      window(14, sc, rc, bc, cc);
      check("conflict_pulses", cc, 1);
      check("conflict_sr_cycles", sc + rc, 0);
      check("conflict_q", Q_EST, 1'b1);
      SET_REQ = 1'b0; CLR_REQ = 1'b0;
      ticks(10);

      // Plain clear drives Q_EST back to 0.
      CLR_REQ = 1'b1;
      window(14, sc, rc, bc, cc);
      check("clear_r_cycles", rc, 2);
      check("clear_s_cycles", sc, 0);
      check("clear_q", Q_EST, 1'b0);
      CLR_REQ = 1'b0;
      ticks(10);

      // Set, then a clear that lands during PULSE_S: S at 8,9 then R at 12,13.
      s_tr = '0; r_tr = '0;
      SET_REQ = 1'b1;
      tick();
      CLR_REQ = 1'b1;
      for (int e = 2; e <= 16; e++) begin
         tick();
         s_tr[e] = S;
         r_tr[e] = R;
      end
      check("queued_s_trace", s_tr, 17'h00300);
      check("queued_r_trace", r_tr, 17'h03000);
      check("queued_final_q", Q_EST, 1'b0);
      SET_REQ = 1'b0; CLR_REQ = 1'b0;
      ticks(10);

      // Reset asserted in the middle of an S pulse.
      SET_REQ = 1'b1;
      ticks(8);
      check("rst_pre_s", S, 1'b1);
      #2 RST = 1'b1;
      #1;
      check("rst_s_drop", S, 1'b0);
      check("rst_busy_drop", BUSY, 1'b0);
      SET_REQ = 1'b0;
      ticks(2);
      #3 RST = 1'b0;
      tick();
      check("rst_release_outputs", {S, R, BUSY, Q_EST, CONFLICT}, 5'b0);
      window(14, sc, rc, bc, cc);
      check("rst_no_stale_pulse", sc + rc + bc + cc, 0);
      check("rst_q_after", Q_EST, 1'b0);

      check("s_r_never_overlap", overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
